irq_ctrl_n: RTL and testbench



---
 rtl/ictrl_pkg.sv | 34 +++
 rtl/irq_src_capture.sv | 36 +++
 rtl/irq_ctrl_n.sv | 137 +++++++++++++
 tb/tb_irq_ctrl_n.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ictrl_pkg.sv
// Shared definitions for the irq_ctrl_n interrupt controller: source indices,
// register word indices (io_addr[11:2]) and CPSR mode constants.
package ictrl_pkg;

  typedef enum logic [3:0] {
    IRQ_VBLANK  = 4'd0,
    IRQ_HBLANK  = 4'd1,
    IRQ_VCOUNT  = 4'd2,
    IRQ_TIMER0  = 4'd3,
    IRQ_TIMER1  = 4'd4,
    IRQ_TIMER2  = 4'd5,
    IRQ_TIMER3  = 4'd6,
    IRQ_SERIAL  = 4'd7,
    IRQ_DMA0    = 4'd8,
    IRQ_DMA1    = 4'd9,
    IRQ_DMA2    = 4'd10,
    IRQ_DMA3    = 4'd11,
    IRQ_KEYPAD  = 4'd12,
    IRQ_GAMEPAK = 4'd13
  } irq_src_e;

  typedef enum logic {
    SRC_EDGE  = 1'b0,
    SRC_LEVEL = 1'b1
  } src_mode_t;

  // Byte addresses 0x200, 0x204, 0x208 expressed as word indices.
  localparam logic [9:0] IE_IF_IDX   = 10'h080;
  localparam logic [9:0] WAITCNT_IDX = 10'h081;
  localparam logic [9:0] IME_IDX     = 10'h082;

  localparam logic [4:0] CPSR_IRQ = 5'b10010;

endpackage

// File: rtl/irq_src_capture.sv
// One interrupt source: edge-history flop plus its sticky IF bit with
// write-1-to-clear; a new event always beats a simultaneous clear.
module irq_src_capture
  import ictrl_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  src_mode_t mode,
  input  logic      src,
  input  logic      clr,
  output logic      q
);

  logic src_q;
  logic if_q;
  logic if_d;
  logic evt;

  assign evt  = (mode == SRC_LEVEL) ? src : (src & ~src_q);
  assign if_d = evt | (if_q & ~clr);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      src_q <= 1'b0;
      if_q  <= 1'b0;
    end else begin
      src_q <= src;
      if_q  <= if_d;
    end
  end

  assign q = if_q;

endmodule

// File: rtl/irq_ctrl_n.sv
// Interrupt controller top: IE/IF/IME/WAITCNT IO registers, priority encoder
// and registered active-low nIRQ. Define ICTRL_IRQ_DELAY_EN to insert an
// IRQ_DELAY-stage shift register ahead of the nIRQ flop.
module irq_ctrl_n
  import ictrl_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 14,
  parameter logic [15:0] LEVEL_MASK = 16'h0000,
  parameter int unsigned IRQ_DELAY  = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic [4:0]         cpu_mode,
  input  logic [11:0]        io_addr,
  input  logic               io_write,
  input  logic [3:0]         io_be,
  input  logic [31:0]        io_wdata,
  output logic [31:0]        io_rdata,
  output logic               io_hit,
  output logic               nIRQ,
  output logic               irq_pending,
  output logic [3:0]         irq_id
);

  if (NUM_SRC < 1 || NUM_SRC > 16) begin : g_bad_num_src
    $error("irq_ctrl_n: NUM_SRC must be 1..16");
  end
  if (IRQ_DELAY < 1 || IRQ_DELAY > 7) begin : g_bad_irq_delay
    $error("irq_ctrl_n: IRQ_DELAY must be 1..7");
  end

  logic [NUM_SRC-1:0] ie_q, ie_d;
  logic [NUM_SRC-1:0] if_bits, if_clr, pend;
  logic [31:0]        waitcnt_q, waitcnt_d;
  logic               ime_q, ime_d;
  logic               nirq_q, irq_term;
  logic               hit_ie_if, hit_waitcnt, hit_ime;
  logic [15:0]        ie_rd, if_rd;

  assign hit_ie_if   = (io_addr[1:0] == 2'b00) && (io_addr[11:2] == IE_IF_IDX);
  assign hit_waitcnt = (io_addr[1:0] == 2'b00) && (io_addr[11:2] == WAITCNT_IDX);
  assign hit_ime     = (io_addr[1:0] == 2'b00) && (io_addr[11:2] == IME_IDX);
  assign io_hit      = hit_ie_if | hit_waitcnt | hit_ime;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_src_capture u_cap (
      .clock   (clock),
      .reset_n (reset_n),
      .mode    (LEVEL_MASK[i] ? SRC_LEVEL : SRC_EDGE),
      .src     (src[i]),
      .clr     (if_clr[i]),
      .q       (if_bits[i])
    );
  end

  // NOTE: every signal driven here gets its default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    ie_d      = ie_q;
    waitcnt_d = waitcnt_q;
    ime_d     = ime_q;
    if_clr    = '0;
    if (io_write && hit_ie_if) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (io_be[i/8])     ie_d[i]   = io_wdata[i];
        if (io_be[2 + i/8]) if_clr[i] = io_wdata[16 + i];
      end
    end
    if (io_write && hit_waitcnt) begin
      for (int b = 0; b < 4; b++) begin
        if (io_be[b]) waitcnt_d[8*b +: 8] = io_wdata[8*b +: 8];
      end
    end
    if (io_write && hit_ime && io_be[0]) ime_d = io_wdata[0];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ie_q      <= '0;
      waitcnt_q <= '0;
      ime_q     <= 1'b0;
    end else begin
      ie_q      <= ie_d;
      waitcnt_q <= waitcnt_d;
      ime_q     <= ime_d;
    end
  end

  assign pend        = ie_q & if_bits;
  assign irq_pending = |pend;

  // Scan downwards so the lowest-numbered pending source is assigned last.
  always_comb begin
    irq_id = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend[i]) irq_id = 4'(i);
    end
  end

  always_comb begin
    ie_rd                = '0;
    if_rd                = '0;
    ie_rd[NUM_SRC-1:0]   = ie_q;
    if_rd[NUM_SRC-1:0]   = if_bits;
    io_rdata             = '0;
    if (hit_ie_if)        io_rdata = {if_rd, ie_rd};
    else if (hit_waitcnt) io_rdata = waitcnt_q;
    else if (hit_ime)     io_rdata = {31'd0, ime_q};
  end

  assign irq_term = ime_q & irq_pending & (cpu_mode != CPSR_IRQ);

`ifdef ICTRL_IRQ_DELAY_EN
  logic [IRQ_DELAY-1:0] dly_q;

  // Stages carry the active-low value, so reset fills them with 1.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dly_q  <= '1;
      nirq_q <= 1'b1;
    end else begin
      dly_q[0] <= ~irq_term;
      for (int k = 1; k < IRQ_DELAY; k++) dly_q[k] <= dly_q[k-1];
      nirq_q <= dly_q[IRQ_DELAY-1];
    end
  end
`else
  always_ff @(posedge clock) begin
    if (!reset_n) nirq_q <= 1'b1;
    else          nirq_q <= ~irq_term;
  end
`endif

  assign nIRQ = nirq_q;

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Self-checking bench for irq_ctrl_n: directed scenarios plus randomized
// traffic compared against a transaction-level model of the register rules.
module tb_irq_ctrl_n;

  localparam int          NS  = 14;
  localparam logic [15:0] LM  = 16'h0808;
  localparam int          DLY = 3;
`ifdef ICTRL_IRQ_DELAY_EN
  localparam int EX = DLY;
`else
  localparam int EX = 0;
`endif
  localparam logic [15:0] VALID    = 16'((32'h1 << NS) - 1);
  localparam logic [4:0]  MODE_IRQ = 5'h12;
  localparam logic [4:0]  MODE_SYS = 5'h1F;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [NS-1:0] src;
  logic [4:0]    cpu_mode;
  logic [11:0]   io_addr;
  logic          io_write;
  logic [3:0]    io_be;
  logic [31:0]   io_wdata;
  logic [31:0]   io_rdata;
  logic          io_hit;
  logic          nIRQ;
  logic          irq_pending;
  logic [3:0]    irq_id;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_ie, m_if, m_prev;
  logic        m_ime, m_nirq;
  logic [31:0] m_wait;
  bit          pipe[$];

  irq_ctrl_n #(.NUM_SRC(NS), .LEVEL_MASK(LM), .IRQ_DELAY(DLY)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .src         (src),
    .cpu_mode    (cpu_mode),
    .io_addr     (io_addr),
    .io_write    (io_write),
    .io_be       (io_be),
    .io_wdata    (io_wdata),
    .io_rdata    (io_rdata),
    .io_hit      (io_hit),
    .nIRQ        (nIRQ),
    .irq_pending (irq_pending),
    .irq_id      (irq_id)
  );

  always #5 clock = ~clock;

  // Register-level model: applies one clock edge worth of architectural rules.
  task automatic model_step();
    logic [15:0] s, ev, clr;
    logic        term;
    s = 16'(src);
    if (!reset_n) begin
      m_ie = '0; m_if = '0; m_prev = '0; m_ime = 1'b0; m_wait = '0; m_nirq = 1'b1;
      pipe.delete();
      repeat (EX) pipe.push_back(1'b1);
      return;
    end
    term = m_ime && ((m_ie & m_if) != 16'h0) && (cpu_mode != MODE_IRQ);
    ev   = (s & LM) | (s & ~m_prev & ~LM);
    clr  = '0;
    if (io_write) begin
      case (io_addr)
        12'h200: for (int b = 0; b < 2; b++) begin
          if (io_be[b])     m_ie[8*b +: 8] = io_wdata[8*b +: 8];
          if (io_be[b + 2]) clr[8*b +: 8]  = io_wdata[16 + 8*b +: 8];
        end
        12'h204: for (int b = 0; b < 4; b++)
          if (io_be[b]) m_wait[8*b +: 8] = io_wdata[8*b +: 8];
        12'h208: if (io_be[0]) m_ime = io_wdata[0];
        default: ;
      endcase
    end
    m_ie   = m_ie & VALID;
    m_if   = ((m_if & ~clr) | ev) & VALID;
    m_prev = s;
    pipe.push_back(!term);
    m_nirq = pipe.pop_front();
  endtask

  function automatic logic [31:0] exp_rdata(input logic [11:0] a);
    case (a)
      12'h200: return {m_if, m_ie};
      12'h204: return m_wait;
      12'h208: return {31'd0, m_ime};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] exp_id();
    logic [15:0] p;
    p = m_ie & m_if;
    for (int i = 0; i < 16; i++) if (p[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic set_addr(input logic [11:0] a);
    io_addr = a;
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
    io_addr = a; io_be = be; io_wdata = d; io_write = 1'b1;
    tick();
    io_write = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] addrs[3];
    addrs = '{12'h200, 12'h204, 12'h208};
    reset_n = 1'b0; src = '0; cpu_mode = MODE_SYS;
    io_addr = '0; io_write = 1'b0; io_be = '0; io_wdata = '0;
    tick(); tick();
    n_checks++; if (nIRQ !== 1'b1) $display("FAIL reset_nirq: got %b want 1", nIRQ); else n_pass++;
    n_checks++; if (irq_pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", irq_pending); else n_pass++;
    n_checks++; if (irq_id !== 4'd0) $display("FAIL reset_id: got %0d want 0", irq_id); else n_pass++;
    reset_n = 1'b1;
    foreach (addrs[i]) begin
      set_addr(addrs[i]);
      n_checks++; if (io_rdata !== 32'd0) $display("FAIL reset_rdata@%h: got %h want 0", addrs[i], io_rdata); else n_pass++;
      n_checks++; if (io_hit !== 1'b1) $display("FAIL hit@%h: got %b want 1", addrs[i], io_hit); else n_pass++;
    end
    set_addr(12'h20C);
    n_checks++; if (io_hit !== 1'b0 || io_rdata !== 32'd0)
      $display("FAIL unmapped_20c: got hit=%b rdata=%h want hit=0 rdata=0", io_hit, io_rdata); else n_pass++;
  endtask

  task automatic test_waitcnt();
    wr(12'h204, 4'b1111, 32'hDEAD_BEEF);
    n_checks++; if (io_rdata !== 32'hDEAD_BEEF) $display("FAIL waitcnt_full: got %h want DEADBEEF", io_rdata); else n_pass++;
    io_be = 4'b0101; io_wdata = 32'h1122_3344; io_write = 1'b1;
    #1;
    n_checks++; if (io_rdata !== 32'hDEAD_BEEF) $display("FAIL read_during_write: got %h want DEADBEEF", io_rdata); else n_pass++;
    tick();
    io_write = 1'b0;
    n_checks++; if (io_rdata !== 32'hDE22_BE44) $display("FAIL waitcnt_bytes: got %h want DE22BE44", io_rdata); else n_pass++;
    wr(12'h208, 4'b1111, 32'hFFFF_FFFF);
    n_checks++; if (io_rdata !== 32'h0000_0001) $display("FAIL ime_read: got %h want 00000001", io_rdata); else n_pass++;
  endtask

  task automatic test_irq_basic();
    wr(12'h200, 4'b0011, 32'h0000_0001);
    set_addr(12'h200);
    src[0] = 1'b1;
    for (int k = 1; k <= 2 + EX; k++) begin
      tick();
      if (k == 1) begin
        src[0] = 1'b0;
        n_checks++; if (io_rdata !== 32'h0001_0001) $display("FAIL basic_if: got %h want 00010001", io_rdata); else n_pass++;
        n_checks++; if (irq_pending !== 1'b1 || irq_id !== 4'd0)
          $display("FAIL basic_pend: got pend=%b id=%0d want pend=1 id=0", irq_pending, irq_id); else n_pass++;
      end
      n_checks++; if (nIRQ !== (k == 2 + EX ? 1'b0 : 1'b1))
        $display("FAIL basic_latency k=%0d: got %b want %b", k, nIRQ, (k == 2 + EX ? 1'b0 : 1'b1)); else n_pass++;
    end
  endtask

  task automatic test_w1c();
    wr(12'h200, 4'b0011, 32'h0001_0001);
    n_checks++; if (io_rdata !== 32'h0001_0001) $display("FAIL w1c_be_low: got %h want 00010001", io_rdata); else n_pass++;
    n_checks++; if (nIRQ !== 1'b0) $display("FAIL w1c_pre_nirq: got %b want 0", nIRQ); else n_pass++;
    wr(12'h200, 4'b1100, 32'h0001_0000);
    n_checks++; if (io_rdata !== 32'h0000_0001) $display("FAIL w1c_clear: got %h want 00000001", io_rdata); else n_pass++;
    n_checks++; if (irq_pending !== 1'b0) $display("FAIL w1c_pending: got %b want 0", irq_pending); else n_pass++;
    n_checks++; if (nIRQ !== 1'b0) $display("FAIL w1c_nirq_hold: got %b want 0", nIRQ); else n_pass++;
    for (int k = 1; k <= 1 + EX; k++) begin
      tick();
      n_checks++; if (nIRQ !== (k == 1 + EX ? 1'b1 : 1'b0))
        $display("FAIL w1c_release k=%0d: got %b want %b", k, nIRQ, (k == 1 + EX ? 1'b1 : 1'b0)); else n_pass++;
    end
  endtask

  task automatic test_edge_level();
    set_addr(12'h200);
    src[2] = 1'b1; src[3] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 5) io_write = 1'b0;
      n_checks++; if (io_rdata[18] !== (c < 5))
        $display("FAIL edge_if2 c=%0d: got %b want %b", c, io_rdata[18], (c < 5)); else n_pass++;
      n_checks++; if (io_rdata[19] !== 1'b1)
        $display("FAIL level_if3 c=%0d: got %b want 1", c, io_rdata[19]); else n_pass++;
      if (c == 4) begin
        io_be = 4'b0100; io_wdata = 32'h000C_0000; io_write = 1'b1;
      end
    end
    src[2] = 1'b0; src[3] = 1'b0;
    tick();
    wr(12'h200, 4'b0100, 32'h000C_0000);
    n_checks++; if (io_rdata[31:16] !== 16'h0000) $display("FAIL edge_level_final: got %h want 0000", io_rdata[31:16]); else n_pass++;
  endtask

  task automatic test_set_wins();
    set_addr(12'h200);
    src[5] = 1'b1; tick(); src[5] = 1'b0; tick();
    n_checks++; if (io_rdata[21] !== 1'b1) $display("FAIL setwins_pre: got %b want 1", io_rdata[21]); else n_pass++;
    src[5] = 1'b1;
    wr(12'h200, 4'b0100, 32'h0020_0000);
    n_checks++; if (io_rdata[21] !== 1'b1) $display("FAIL setwins_same_cycle: got %b want 1", io_rdata[21]); else n_pass++;
    wr(12'h200, 4'b0100, 32'h0020_0000);
    n_checks++; if (io_rdata[21] !== 1'b0) $display("FAIL setwins_clear_no_edge: got %b want 0", io_rdata[21]); else n_pass++;
    src[5] = 1'b0;
  endtask

  task automatic test_priority();
    wr(12'h200, 4'b1100, 32'hFFFF_0000);
    wr(12'h200, 4'b0011, 32'h0000_0030);
    wr(12'h208, 4'b0001, 32'h0000_0001);
    src[4] = 1'b1; src[5] = 1'b1; tick(); src[4] = 1'b0; src[5] = 1'b0;
    set_addr(12'h200);
    n_checks++; if (io_rdata !== 32'h0030_0030) $display("FAIL prio_regs: got %h want 00300030", io_rdata); else n_pass++;
    n_checks++; if (irq_id !== 4'd4) $display("FAIL prio_id: got %0d want 4", irq_id); else n_pass++;
    repeat (EX + 2) tick();
    n_checks++; if (nIRQ !== 1'b0) $display("FAIL prio_nirq: got %b want 0", nIRQ); else n_pass++;
    cpu_mode = MODE_IRQ;
    repeat (EX + 2) tick();
    n_checks++; if (nIRQ !== 1'b1 || irq_pending !== 1'b1)
      $display("FAIL irq_mode_mask: got nirq=%b pend=%b want nirq=1 pend=1", nIRQ, irq_pending); else n_pass++;
    cpu_mode = MODE_SYS;
    repeat (EX + 2) tick();
    n_checks++; if (nIRQ !== 1'b0) $display("FAIL mode_unmask: got %b want 0", nIRQ); else n_pass++;
    wr(12'h208, 4'b0001, 32'h0000_0000);
    repeat (EX + 2) tick();
    n_checks++; if (nIRQ !== 1'b1 || irq_pending !== 1'b1)
      $display("FAIL ime_mask: got nirq=%b pend=%b want nirq=1 pend=1", nIRQ, irq_pending); else n_pass++;
    wr(12'h208, 4'b0000, 32'h0000_0001);
    n_checks++; if (io_rdata !== 32'd0) $display("FAIL ime_no_be: got %h want 0", io_rdata); else n_pass++;
    wr(12'h200, 4'b0100, 32'h0010_0000);
    n_checks++; if (irq_id !== 4'd5) $display("FAIL prio_next_id: got %0d want 5", irq_id); else n_pass++;
  endtask

  task automatic test_reset_mid();
    wr(12'h200, 4'b0011, 32'h0000_0001);
    wr(12'h208, 4'b0001, 32'h0000_0001);
    src[0] = 1'b1; tick(); src[0] = 1'b0; tick();
    reset_n = 1'b0;
    tick();
    set_addr(12'h200);
    n_checks++; if (nIRQ !== 1'b1) $display("FAIL midreset_nirq: got %b want 1", nIRQ); else n_pass++;
    n_checks++; if (io_rdata !== 32'd0) $display("FAIL midreset_ieif: got %h want 0", io_rdata); else n_pass++;
    n_checks++; if (irq_pending !== 1'b0 || irq_id !== 4'd0)
      $display("FAIL midreset_pend: got pend=%b id=%0d want 0/0", irq_pending, irq_id); else n_pass++;
    reset_n = 1'b1;
    for (int k = 1; k <= EX + 2; k++) begin
      tick();
      n_checks++; if (nIRQ !== 1'b1) $display("FAIL midreset_retained k=%0d: got %b want 1", k, nIRQ); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [11:0] a;
    for (int n = 0; n < 1500; n++) begin
      n_checks++; if (nIRQ !== m_nirq) $display("FAIL rnd_nirq n=%0d: got %b want %b", n, nIRQ, m_nirq); else n_pass++;
      n_checks++; if (irq_pending !== ((m_ie & m_if) != 16'h0))
        $display("FAIL rnd_pending n=%0d: got %b want %b", n, irq_pending, ((m_ie & m_if) != 16'h0)); else n_pass++;
      n_checks++; if (irq_id !== exp_id()) $display("FAIL rnd_id n=%0d: got %0d want %0d", n, irq_id, exp_id()); else n_pass++;
      n_checks++; if (io_rdata !== exp_rdata(io_addr))
        $display("FAIL rnd_rdata n=%0d addr=%h: got %h want %h", n, io_addr, io_rdata, exp_rdata(io_addr)); else n_pass++;
      n_checks++; if (io_hit !== (exp_rdata(12'h200) == exp_rdata(io_addr) && io_addr == 12'h200 ||
                                  io_addr == 12'h204 || io_addr == 12'h208))
        $display("FAIL rnd_hit n=%0d addr=%h: got %b", n, io_addr, io_hit); else n_pass++;
      case ($urandom_range(0, 4))
        0: a = 12'h200;
        1: a = 12'h204;
        2: a = 12'h208;
        3: a = 12'($urandom) & 12'hFFC;
        default: a = 12'($urandom);
      endcase
      io_addr  = a;
      io_write = ($urandom_range(0, 2) == 0);
      io_be    = 4'($urandom);
      io_wdata = $urandom;
      src      = NS'($urandom & $urandom);
      cpu_mode = ($urandom_range(0, 3) == 0) ? MODE_IRQ : MODE_SYS;
      reset_n  = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_waitcnt();
    test_irq_basic();
    test_w1c();
    test_edge_level();
    test_set_wins();
    test_priority();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
